wll_fifo_arb: RTL
=================

WLL_FIFO_ARB -- requirements
Module: wll_fifo_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; DATA_WIDTH, default 8, word width; MAX_BURST, default 4, maximum words per grant.
REQ-002 Clock and reset SHALL be one clock and one asynchronous, active-low reset: clk input 1 (clock); rst_n input 1 (asynchronous active-low reset).
REQ-003 en  input  1  global enable; low blocks new grants and stalls transfers.
REQ-004 req_valid  input  NREQ  per-requester word valid.
REQ-005 req_data  input  NREQ*DATA_WIDTH  per-requester word; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 req_last  input  NREQ  per-requester last word of burst.
REQ-007 req_ready  output  NREQ  per-requester accept.
REQ-008 fifo_full  input  1  full flag from the downstream FIFO.
REQ-009 fifo_wr_en  output  1  FIFO write strobe.
REQ-010 fifo_data  output  DATA_WIDTH  FIFO write data.
REQ-011 grant_id  output  clog2(NREQ)  current or last granted requester.
REQ-012 busy  output  1  high while in BURST.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and BURST.
REQ-014 In IDLE with en=1 and any req_valid set, the block SHALL pick the first valid requester searching upward from (last_grant+1) mod NREQ with wrap-around, register it into grant_id, clear burst_cnt, and enter BURST on the next edge.
REQ-015 In IDLE, req_ready SHALL be all zero and fifo_wr_en SHALL be 0.
REQ-016 In BURST, req_ready[i] SHALL equal (i==grant_id) & en & ~fifo_full, combinationally; all other bits SHALL be 0.
REQ-017 A transfer SHALL occur when req_valid[grant_id] & req_ready[grant_id]; in that cycle fifo_wr_en=1 and fifo_data=req_data of grant_id, with zero latency (combinational).
REQ-018 fifo_data SHALL be 0 whenever fifo_wr_en=0.
REQ-019 burst_cnt SHALL increment by 1 on each transfer and SHALL saturate conceptually at MAX_BURST; its width SHALL be clog2(MAX_BURST+1).
REQ-020 BURST SHALL return to IDLE on any of these events, and last_grant SHALL be set to grant_id on the same edge: (a) a transfer with req_last[grant_id]=1; (b) the transfer that makes burst_cnt reach MAX_BURST; (c) req_valid[grant_id]=0 while en=1 and fifo_full=0.
REQ-021 fifo_full=1 or en=0 in BURST SHALL stall the burst: no transfer, burst_cnt held, state held, and no release under REQ-020(c).
REQ-022 One idle arbitration cycle SHALL separate consecutive bursts; the minimum grant-to-grant spacing is burst length + 1 cycles.
REQ-023 Requests arriving at non-granted requesters during BURST SHALL be ignored until the next IDLE cycle.
REQ-024 grant_id SHALL hold its value in IDLE.

Reset
REQ-025 While rst_n=0: state=IDLE, grant_id=0, last_grant=NREQ-1 (requester 0 has first priority after reset), burst_cnt=0, fifo_wr_en=0, fifo_data=0, req_ready=0, busy=0.
REQ-026 Reset asserted mid-burst SHALL abort the burst immediately, with no further writes.

Structure
REQ-027 A shared package wll_fifo_pkg SHALL hold the DATA_WIDTH and NREQ defaults and the state enum {IDLE, BURST}.
REQ-028 Round-robin selection SHALL be a separate combinational sub-module, wll_rr_pick: inputs req vector and start index; outputs found and index.

Verification
REQ-029 Scenario: reset, then only req 0 valid with words AA, BB, last on BB -> grant_id=0 one cycle later; fifo_wr_en high two consecutive cycles with AA then BB; then IDLE.
REQ-030 Scenario: all 4 requesters valid continuously, no last, MAX_BURST=4 -> grants in order 0,1,2,3,0; 4 writes per grant; one idle cycle between grants.
REQ-031 Scenario: fifo_full raised for 3 cycles mid-burst after word 01 -> req_ready=0 and no write for 3 cycles; words 02, 03 follow with none lost or duplicated.
REQ-032 Scenario: en dropped in IDLE with req 2 valid -> no grant until en returns; en dropped during a burst -> stall as for full.
REQ-033 Scenario: granted req 1 drops valid after 1 word -> return to IDLE; next grant goes to req 2 if valid, else wrap to 3, 0, 1.
REQ-034 Scenario: rst_n asserted while busy=1 -> all outputs at REQ-025 values in the same cycle; after release, req 0 wins over req 3 when both are valid.

Source files
------------

// File: rtl/wll_fifo_pkg.sv
// Shared defaults, state encoding and helpers for the round-robin FIFO write arbiter.
package wll_fifo_pkg;

  localparam int DEFAULT_NREQ       = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_MAX_BURST  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Index width that stays legal for a single-requester build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wll_rr_pick.sv
// Combinational round-robin search: first set bit of req at or above start, wrapping.
module wll_rr_pick
  import wll_fifo_pkg::*;
#(
  parameter  int NREQ = DEFAULT_NREQ,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic            found,
  output logic [IW-1:0]   index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == (int'(start) + k) % NREQ)) begin
          found = 1'b1;
          index = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/wll_fifo_arb.sv
// Round-robin burst arbiter moving words from NREQ requesters into one downstream FIFO.
module wll_fifo_arb
  import wll_fifo_pkg::*;
#(
  parameter  int NREQ       = DEFAULT_NREQ,
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int MAX_BURST  = DEFAULT_MAX_BURST,
  localparam int IW         = idx_width(NREQ),
  localparam int CW         = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]            req_last,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_WIDTH-1:0]      fifo_data,
  output logic [IW-1:0]              grant_id,
  output logic                       busy
);

  state_e                state, state_nxt;
  logic [IW-1:0]         last_grant;
  logic [CW-1:0]         burst_cnt;
  logic [IW-1:0]         pick_start;
  logic                  pick_found;
  logic [IW-1:0]         pick_index;
  logic                  gnt_valid;
  logic                  gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  can_move;
  logic                  start_burst;

  assign pick_start  = (last_grant == IW'(NREQ - 1)) ? '0 : last_grant + 1'b1;
  assign can_move    = en & ~fifo_full;
  assign start_burst = (state == IDLE) & en & pick_found;
  assign busy        = (state == BURST);

  wll_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .start (pick_start),
    .found (pick_found),
    .index (pick_index)
  );

  // Select the granted requester's handshake and data lanes.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IW'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        gnt_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A stalled burst (full or disabled) neither transfers nor releases.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    unique case (state)
      IDLE: begin
        if (en && pick_found) state_nxt = BURST;
      end
      BURST: begin
        if (can_move) begin
          for (int i = 0; i < NREQ; i++) req_ready[i] = (grant_id == IW'(i));
          if (gnt_valid) begin
            fifo_wr_en = 1'b1;
            fifo_data  = gnt_data;
            if (gnt_last || burst_cnt == CW'(MAX_BURST - 1)) state_nxt = IDLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
      burst_cnt  <= '0;
    end else begin
      if (start_burst) begin
        grant_id  <= pick_index;
        burst_cnt <= '0;
      end else if (fifo_wr_en) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (state == BURST && state_nxt == IDLE) last_grant <= grant_id;
    end
  end

endmodule
